kernel_loader: RTL and testbench
================================

# kernel_loader

Sequencer that fills the weight registers of a row of PE elements ahead of a convolution pass. On a start request it reads NUM_PE consecutive bfloat16 weights from the synchronous weight SRAM and delivers each one on a shared weight bus, together with a one-hot load strobe that selects the PE element which captures it. It sits between the weight memory and the PE array, and acts as the driving end of the PE `weight` / `ker_load` interface.

## Interface
- DATA_WIDTH, 16, weight word width (bfloat16)
- NUM_PE, 9, number of PE elements served; legal range ≥2
- ADDR_WIDTH, 12, weight SRAM address width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  load request; sampled only while busy=0
- base_addr  in  ADDR_WIDTH  address of the weight for PE 0; sampled with start
- busy  out  1  a load sequence is in progress
- done  out  1  single-cycle pulse after the last PE has been loaded
- mem_rd_en  out  1  SRAM read enable
- mem_addr  out  ADDR_WIDTH  SRAM read address
- mem_rd_data  in  DATA_WIDTH  SRAM read data, valid the cycle after a read enable
- weight_out  out  DATA_WIDTH  shared weight bus to all PE `weight` inputs
- ker_load  out  NUM_PE  one-hot load strobes; bit i drives `ker_load` of PE i

## Operation
- All outputs are registered. Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, weight_out=0, ker_load=0. State is IDLE.
- FSM states:
  - IDLE → FETCH on start=1. Capture base_addr. Read counter resets to 0.
  - FETCH issues one read per cycle: mem_rd_en=1, mem_addr=base_addr+rd_cnt, where rd_cnt runs from 0 to NUM_PE-1. It moves to DRAIN after the read with rd_cnt=NUM_PE-1.
  - DRAIN lasts exactly 2 cycles, while the two-stage pipeline empties. It then moves to IDLE and pulses done.
- Pipeline: a one-bit valid and a PE index travel with each read. Stage 1 is the SRAM latency. In stage 2, weight_out<=mem_rd_data and ker_load<=(1<<index) are registered together.
- Address arithmetic is modulo 2^ADDR_WIDTH. A base near the top wraps to 0 with no error.
- weight_out holds its last value when no strobe is active. ker_load is all-zero outside load cycles and never has more than one bit set.
- Weight i always goes to PE i, in ascending order, one per cycle, with no gaps.
- start while busy=1 is ignored, with no queuing. start in the same cycle that done=1 is accepted, because busy=0 in that cycle.
- Asserting rst_n mid-sequence aborts it immediately. All outputs go to reset values, no done is produced, and PE registers keep whatever was already loaded.
- No backpressure: the SRAM always answers with a fixed 1-cycle latency.

## Timing
- start sampled high at edge T.
- Reads are issued in cycles T+1 .. T+NUM_PE.
- ker_load[i] is high in cycle T+3+i, with weight_out equal to mem[base+i]. The PE captures at the end of that cycle.
- busy is high from T+1 through T+NUM_PE+2. done is high only in cycle T+NUM_PE+3, with busy=0.
- Total start-to-done latency is NUM_PE+3 cycles. The minimum start-to-start period is NUM_PE+3 cycles.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, FETCH, DRAIN);
  - the localparam SRAM_RD_LATENCY=1;
  - the DRAIN length derived from it (SRAM_RD_LATENCY+1).
- Index width is $clog2(NUM_PE), computed locally.
- Single module. No sub-module is warranted. The one-hot decode is one shift expression.

## Test plan
- Basic load: NUM_PE=9, base_addr=0x010, mem[0x010+i]=0x3F80+i → ker_load bit i in cycle T+3+i with weight_out=0x3F80+i. done at T+12. Bench PE models hold 0x3F80..0x3F88.
- Address wrap: ADDR_WIDTH=12, base_addr=0xFFC → reads at 0xFFC, 0xFFD, 0xFFE, 0xFFF, 0x000 .. 0x004. PE 4 receives mem[0x000].
- Start while busy: second start pulsed at T+5 with a different base → ignored. Addresses and done timing are identical to the single-start case.
- Back-to-back: start held high continuously → the second sequence's first read is at T+NUM_PE+4. Exactly one done per sequence. busy is low for exactly one cycle between sequences.
- Reset mid-sequence: rst_n low at T+6 → all outputs 0 asynchronously, no done. After release, a new start at base 0x020 loads all 9 PEs correctly.
- Strobe integrity: over a full random-base run, check $onehot0(ker_load) every cycle, mem_rd_en never high outside FETCH, and weight_out stable when ker_load==0.

Source files
------------

// File: rtl/kernel_loader_pkg.sv
// Shared definitions for the kernel weight loader: FSM states and SRAM timing.
package kernel_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Weight SRAM answers a read one cycle after the enable.
    localparam int SRAM_RD_LATENCY = 1;

    // After the last read, the SRAM stage plus the output register must empty.
    localparam int DRAIN_CYCLES = SRAM_RD_LATENCY + 1;

endpackage

// File: rtl/kernel_loader.sv
// Kernel loader: streams NUM_PE consecutive weights from SRAM onto the shared
// PE weight bus, one PE per cycle, with a one-hot ker_load strobe.
module kernel_loader
    import kernel_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PE     = 9,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic [NUM_PE-1:0]     ker_load
);

    localparam int IDX_W = $clog2(NUM_PE);
    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(DRAIN_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        rd_cnt_q, rd_cnt_d;   // PE index of the read on the bus now
    logic [DRN_W-1:0]        drn_cnt_q, drn_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    vld1_q, vld1_d;       // SRAM stage: read in flight
    logic [IDX_W-1:0]        idx1_q, idx1_d;       // SRAM stage: its PE index
    logic [DATA_WIDTH-1:0]   weight_q, weight_d;
    logic [NUM_PE-1:0]       kload_q, kload_d;

    // Sequencer: accept start, issue NUM_PE reads, wait for the pipe to drain.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        drn_cnt_d = drn_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    busy_d   = 1'b1;
                    rd_en_d  = 1'b1;
                    addr_d   = base_addr;
                    rd_cnt_d = '0;
                end
            end
            ST_FETCH: begin
                if (rd_cnt_q == LAST_IDX) begin
                    state_d   = ST_DRAIN;
                    drn_cnt_d = '0;
                end else begin
                    rd_en_d  = 1'b1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);  // wraps modulo 2^ADDR_WIDTH
                    rd_cnt_d = rd_cnt_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drn_cnt_q == LAST_DRN) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    drn_cnt_d = drn_cnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Data pipeline: tag each read with its PE index, then register weight and strobe together.
    always_comb begin
        vld1_d   = rd_en_q;
        idx1_d   = rd_cnt_q;
        kload_d  = vld1_q ? (NUM_PE'(1) << idx1_q) : '0;
        weight_d = vld1_q ? mem_rd_data : weight_q;
    end

    // State and output registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            drn_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            vld1_q    <= 1'b0;
            idx1_q    <= '0;
            weight_q  <= '0;
            kload_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            drn_cnt_q <= drn_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            vld1_q    <= vld1_d;
            idx1_q    <= idx1_d;
            weight_q  <= weight_d;
            kload_q   <= kload_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_rd_en  = rd_en_q;
    assign mem_addr   = addr_q;
    assign weight_out = weight_q;
    assign ker_load   = kload_q;

endmodule

// File: tb/tb_kernel_loader.sv
// Bench for kernel_loader: SRAM and PE register models, a timing-rule reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_kernel_loader;

    localparam int DW    = 16;
    localparam int N     = 9;
    localparam int AW    = 12;
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] weight_out;
    logic [N-1:0]  ker_load;

    logic [DW-1:0] mem    [MEMSZ];
    logic [DW-1:0] pe_reg [N];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // reference model state: edge at which the current sequence was accepted
    bit            has_seq = 1'b0;
    int            ts = 0;
    int            free_edge = 0;
    logic [AW-1:0] m_base = '0;
    logic [DW-1:0] last_w = '0;

    int            done_cnt = 0;
    int            last_done_cyc = -1;
    bit            log_en = 1'b0;
    logic [AW-1:0] rd_log [$];

    kernel_loader #(.DATA_WIDTH(DW), .NUM_PE(N), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .weight_out  (weight_out),
        .ker_load    (ker_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // synchronous SRAM, one-cycle read latency
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    // PE weight registers (not reset, they keep what was loaded)
    always @(posedge clk)
        for (int i = 0; i < N; i++) if (ker_load[i]) pe_reg[i] <= weight_out;

    // Model: a start seen at an edge while the loader is free opens a sequence
    always @(posedge clk) begin
        cyc++;
        if (rst_n && cyc >= free_edge && start) begin
            has_seq   = 1'b1;
            ts        = cyc;
            m_base    = base_addr;
            free_edge = cyc + N + 3;
        end
    end

    always @(negedge rst_n) begin
        has_seq   = 1'b0;
        free_edge = 0;
        last_w    = '0;
    end

    // Per-cycle compare: offsets d from the accepting edge give every output
    always @(negedge clk) begin
        int            d;
        logic [N-1:0]  ekl;
        logic [AW-1:0] a;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_en", mem_rd_en, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_weight", weight_out, 0);
            chk("rst_ker_load", ker_load, 0);
        end else begin
            d   = has_seq ? (cyc - ts) : -100;
            ekl = '0;
            if (d >= 2 && d <= N + 1) begin
                ekl    = N'(1) << (d - 2);
                a      = m_base + AW'(d - 2);
                last_w = mem[a];
            end
            chk("busy", busy, (d >= 0 && d <= N + 1) ? 1 : 0);
            chk("done", done, (d == N + 2) ? 1 : 0);
            chk("rd_en", mem_rd_en, (d >= 0 && d < N) ? 1 : 0);
            if (d >= 0 && d < N) chk("rd_addr", mem_addr, 32'(AW'(m_base + AW'(d))));
            chk("ker_load", ker_load, 32'(ekl));
            chk("weight", weight_out, last_w);
            chk("kl_onehot0", 32'($onehot0(ker_load)), 1);
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (log_en && mem_rd_en) rd_log.push_back(mem_addr);
    end

    task automatic pulse_start(input logic [AW-1:0] b, output int edge_no);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        edge_no   = cyc + 1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
    endtask

    initial begin
        int t, dc0;
        logic [AW-1:0] a;
        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'($urandom);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_kl", ker_load, 0);
        #2 rst_n = 1'b1;

        // basic load at 0x010
        for (int i = 0; i < N; i++) mem[12'h010 + i] = 16'h3F80 + DW'(i);
        dc0 = done_cnt;
        pulse_start(12'h010, t);
        repeat (N + 6) @(negedge clk);
        chk("basic_done_lat", last_done_cyc - t, N + 2);
        chk("basic_done_cnt", done_cnt - dc0, 1);
        for (int i = 0; i < N; i++) chk("basic_pe", pe_reg[i], 16'h3F80 + i);

        // address wrap from 0xFFC
        rd_log.delete();
        log_en = 1'b1;
        pulse_start(12'hFFC, t);
        repeat (N + 6) @(negedge clk);
        log_en = 1'b0;
        chk("wrap_nreads", rd_log.size(), N);
        chk("wrap_first", rd_log[0], 12'hFFC);
        chk("wrap_pe4_addr", rd_log[4], 12'h000);
        chk("wrap_last", rd_log[N-1], 12'h004);
        chk("wrap_pe4", pe_reg[4], mem[0]);
        for (int i = 0; i < N; i++) begin
            a = 12'hFFC + AW'(i);
            chk("wrap_pe", pe_reg[i], mem[a]);
        end

        // start while busy is ignored
        rd_log.delete();
        log_en = 1'b1;
        dc0 = done_cnt;
        pulse_start(12'h100, t);
        repeat (3) @(negedge clk);
        start = 1'b1;
        base_addr = 12'h300;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        log_en = 1'b0;
        chk("busy_ign_done_cnt", done_cnt - dc0, 1);
        chk("busy_ign_done_lat", last_done_cyc - t, N + 2);
        chk("busy_ign_nreads", rd_log.size(), N);
        chk("busy_ign_last", rd_log[N-1], 12'h108);

        // back-to-back with start held high
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        t = cyc + 1;
        repeat (N + 4) begin
            base_addr = AW'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2 * N + 8) @(negedge clk);
        chk("b2b_done_cnt", done_cnt - dc0, 2);
        chk("b2b_done_lat", last_done_cyc - t, 2 * N + 5);

        // reset mid-sequence
        for (int i = 0; i < N; i++) mem[12'h020 + i] = DW'($urandom);
        dc0 = done_cnt;
        pulse_start(12'h050, t);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_kl", ker_load, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_weight", weight_out, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        pulse_start(12'h020, t);
        repeat (N + 6) @(negedge clk);
        chk("after_rst_done", done_cnt - dc0, 1);
        for (int i = 0; i < N; i++) chk("after_rst_pe", pe_reg[i], mem[12'h020 + i]);

        // random starts and bases, checked every cycle by the model
        repeat (600) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            base_addr = AW'($urandom);
        end
        start = 1'b0;
        repeat (N + 6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
